// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group size,
// group count helper and the stage-1 payload carried between the two stages.
package cla_pkg;

    localparam int GROUP     = 4;
    localparam int MAX_WIDTH = 64;
    localparam int MAX_NG    = MAX_WIDTH / GROUP;

    function automatic int ngroups(input int width);
        return width / GROUP;
    endfunction

    // Sized for the widest legal adder; narrower instances leave upper bits zero.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] p;
        logic [MAX_WIDTH-1:0] g;
        logic [MAX_NG-1:0]    gg;
        logic [MAX_NG-1:0]    pp;
        logic                 c0;
    } s1_payload_t;

endpackage

// File: rtl/cla_pipe_adder_clg.sv
// Flat N-input carry-lookahead generator: every carry is a two-level
// sum of products over g/p/cin, with no ripple between positions.
module clg_group
    import cla_pkg::*;
#(
    parameter int N = GROUP
) (
    input  logic [N-1:0] g,
    input  logic [N-1:0] p,
    input  logic         cin,
    output logic [N-1:0] c,
    output logic         gout,
    output logic         pout
);

    // Carry out of position i: OR over j of g[j] & p[j+1..i], plus cin & p[0..i].
    function automatic logic carry_out(input logic [N-1:0] gv, input logic [N-1:0] pv,
                                       input logic ci, input int i);
        logic res;
        logic term;
        res = ci;
        for (int k = 0; k < N; k++) begin
            if (k <= i) res = res & pv[k];
        end
        for (int j = 0; j < N; j++) begin
            if (j <= i) begin
                term = gv[j];
                for (int k = 0; k < N; k++) begin
                    if (k > j && k <= i) term = term & pv[k];
                end
                res = res | term;
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            c[i] = carry_out(g, p, cin, i);
        end
    end

    assign gout = carry_out(g, p, 1'b0, N - 1);
    assign pout = &p;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with an elastic
// valid/ready handshake and carry, overflow and zero flags.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = ngroups(WIDTH);

    if ((WIDTH % GROUP) != 0 || WIDTH < GROUP || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 in the range 4..64");
    end

    logic vld_p1;
    logic vld_p2;
    logic adv1;
    logic adv2;

    assign adv2      = ~vld_p2 | out_ready;
    assign adv1      = ~vld_p1 | adv2;
    assign in_ready  = adv1;
    assign out_valid = vld_p2;

    // ---- stage 1: operand conditioning, bit and group generate/propagate ----
    logic [WIDTH-1:0] bb_p0;
    logic [WIDTH-1:0] g_p0;
    logic [WIDTH-1:0] p_p0;
    logic [NG-1:0]    gg_p0;
    logic [NG-1:0]    pp_p0;
    logic             c0_p0;
    s1_payload_t      pay_p0;
    s1_payload_t      pay_p1;

    always_comb begin
        bb_p0 = sub ? ~b : b;
        c0_p0 = sub ? 1'b1 : cin;
        g_p0  = a & bb_p0;
        p_p0  = a ^ bb_p0;
        for (int k = 0; k < NG; k++) begin
            gg_p0[k] = g_p0[GROUP*k+3]
                     | (p_p0[GROUP*k+3] & g_p0[GROUP*k+2])
                     | (p_p0[GROUP*k+3] & p_p0[GROUP*k+2] & g_p0[GROUP*k+1])
                     | (p_p0[GROUP*k+3] & p_p0[GROUP*k+2] & p_p0[GROUP*k+1] & g_p0[GROUP*k]);
            pp_p0[k] = &p_p0[GROUP*k +: GROUP];
        end
        pay_p0               = '0;
        pay_p0.p[WIDTH-1:0]  = p_p0;
        pay_p0.g[WIDTH-1:0]  = g_p0;
        pay_p0.gg[NG-1:0]    = gg_p0;
        pay_p0.pp[NG-1:0]    = pp_p0;
        pay_p0.c0            = c0_p0;
    end

    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            pay_p1 <= pay_p0;
        end
    end

    // ---- stage 2: group carries, bit carries, sum and flags ----
    logic [WIDTH-1:0] p_p1;
    logic [WIDTH-1:0] g_p1;
    logic [WIDTH-1:0] cbit_p1;
    logic [WIDTH-1:0] cinb_p1;
    logic [WIDTH-1:0] sum_p1;
    logic [NG-1:0]    cgrp_p1;
    logic [NG:0]      cg_p1;
    logic             cout_p1;
    logic             ovf_p1;
    logic             zero_p1;
    logic             grp_gout;
    logic             grp_pout;
    logic [NG-1:0]    bit_gout;
    logic [NG-1:0]    bit_pout;

    assign p_p1 = pay_p1.p[WIDTH-1:0];
    assign g_p1 = pay_p1.g[WIDTH-1:0];

    clg_group #(.N(NG)) u_grp (
        .g    (pay_p1.gg[NG-1:0]),
        .p    (pay_p1.pp[NG-1:0]),
        .cin  (pay_p1.c0),
        .c    (cgrp_p1),
        .gout (grp_gout),
        .pout (grp_pout)
    );

    assign cg_p1 = {cgrp_p1, pay_p1.c0};

    for (genvar k = 0; k < NG; k++) begin : g_bits
        clg_group #(.N(GROUP)) u_bit (
            .g    (g_p1[GROUP*k +: GROUP]),
            .p    (p_p1[GROUP*k +: GROUP]),
            .cin  (cg_p1[k]),
            .c    (cbit_p1[GROUP*k +: GROUP]),
            .gout (bit_gout[k]),
            .pout (bit_pout[k])
        );
    end

    // Carry into bit i is the carry out of bit i-1; bit 0 takes the adder carry-in.
    assign cinb_p1 = {cbit_p1[WIDTH-2:0], pay_p1.c0};
    assign sum_p1  = p_p1 ^ cinb_p1;
    assign cout_p1 = cg_p1[NG];
    assign ovf_p1  = cinb_p1[WIDTH-1] ^ cg_p1[NG];
    assign zero_p1 = ~|sum_p1;

    // Lookahead by-products that the adder does not need.
    logic unused_ok;
    assign unused_ok = ^{pay_p1, grp_gout, grp_pout, bit_gout, bit_pout, cbit_p1[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b1;
        end else begin
            if (adv1) vld_p1 <= in_valid;
            if (adv2) vld_p2 <= vld_p1;
            if (adv2 && vld_p1) begin
                sum  <= sum_p1;
                cout <= cout_p1;
                ovf  <= ovf_p1;
                zero <= zero_p1;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder at widths 4, 8, 32 and 64: directed table, handshake
// sequences and random traffic scored against an arithmetic reference model.
module tb_cla_pipe_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    typedef struct {
        string       nm;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        exp_t        res;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic        cin_in;
    logic        sub_in;
    logic [3:0]  rdy;
    logic [3:0]  ov;
    logic [3:0]  o_cout;
    logic [3:0]  o_ovf;
    logic [3:0]  o_zero;
    logic [63:0] o_sum [4];

    int   total = 0;
    int   bad   = 0;
    int   npop  = 0;
    int   widths [4] = '{4, 8, 32, 64};
    exp_t q [4][$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int WD = (gi == 0) ? 4 : (gi == 1) ? 8 : (gi == 2) ? 32 : 64;
        logic [WD-1:0] s;
        cla_pipe_adder #(.WIDTH(WD)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (rdy[gi]),
            .a         (a_in[WD-1:0]),
            .b         (b_in[WD-1:0]),
            .cin       (cin_in),
            .sub       (sub_in),
            .out_valid (ov[gi]),
            .out_ready (out_ready),
            .sum       (s),
            .cout      (o_cout[gi]),
            .ovf       (o_ovf[gi]),
            .zero      (o_zero[gi])
        );
        assign o_sum[gi] = 64'(s);
    end

    // Reference: plain modular arithmetic; overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic s);
        logic [64:0] mask, av, bv, full;
        exp_t r;
        mask   = (65'd1 << w) - 65'd1;
        av     = {1'b0, a} & mask;
        bv     = {1'b0, b} & mask;
        if (s) bv = ~bv & mask;
        full   = av + bv + (s ? 65'd1 : 65'(ci));
        r.sum  = full[63:0] & mask[63:0];
        r.cout = full[w];
        r.ovf  = (av[w-1] == bv[w-1]) && (full[w-1] != av[w-1]);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    function automatic exp_t act(input int i);
        exp_t r;
        r.sum  = o_sum[i];
        r.cout = o_cout[i];
        r.ovf  = o_ovf[i];
        r.zero = o_zero[i];
        return r;
    endfunction

    function automatic vec_t mkvec(input string nm, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic s, input logic [63:0] es,
                                   input logic ec, input logic ev, input logic ez);
        vec_t v;
        v.nm = nm; v.a = a; v.b = b; v.cin = ci; v.sub = s;
        v.res.sum = es; v.res.cout = ec; v.res.ovf = ev; v.res.zero = ez;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] actual, input logic [63:0] req);
        total++;
        if (actual !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, actual, req);
        end
    endtask

    task automatic chk_res(input string nm, input exp_t actual, input exp_t req);
        total++;
        if (actual !== req) begin
            bad++;
            $display("FAIL %s: actual sum=%0h cout=%b ovf=%b zero=%b required sum=%0h cout=%b ovf=%b zero=%b",
                     nm, actual.sum, actual.cout, actual.ovf, actual.zero,
                     req.sum, req.cout, req.ovf, req.zero);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: transfers are decided by the values present just before the edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            for (int i = 0; i < 4; i++) q[i].delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ov[i] && out_ready) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("w%0d unexpected output", widths[i]), 64'd1, 64'd0);
                    end else begin
                        e = q[i].pop_front();
                        chk_res($sformatf("w%0d result", widths[i]), act(i), e);
                    end
                    if (i == 2) npop++;
                end
                if (in_valid && rdy[i]) q[i].push_back(model(widths[i], a_in, b_in, cin_in, sub_in));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int lat;
        a_in = v.a; b_in = v.b; cin_in = v.cin; sub_in = v.sub;
        in_valid = 1'b1;
        #1;
        chk({v.nm, " in_ready"}, 64'(rdy[2]), 64'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!ov[2] && lat < 10) begin
            tick();
            lat++;
        end
        chk({v.nm, " latency"}, 64'(lat), 64'd2);
        chk_res(v.nm, act(2), v.res);
    endtask

    vec_t        tbl [8];
    logic [63:0] bp_a [4];
    logic [63:0] bp_b [4];

    initial begin
        int   sent, base, c, cnt;
        logic acc, prev_stall;
        exp_t prev, rst_exp;

        tbl[0] = mkvec("add wrap",     64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0,        1'b1, 1'b0, 1'b1);
        tbl[1] = mkvec("add ovf",      64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1, 1'b0);
        tbl[2] = mkvec("sub borrow",   64'h5,         64'h7, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        tbl[3] = mkvec("sub ovf",      64'h8000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        tbl[4] = mkvec("add cin",      64'h1234_5678, 64'h1111_1111, 1'b1, 1'b0, 64'h2345_678A, 1'b0, 1'b0, 1'b0);
        tbl[5] = mkvec("sub ign cin",  64'hA,         64'hA, 1'b1, 1'b1, 64'h0,        1'b1, 1'b0, 1'b1);
        tbl[6] = mkvec("add neg ovf",  64'h8000_0000, 64'h8000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1);
        tbl[7] = mkvec("chain corner", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a_in = 64'h1234; b_in = 64'h5678; cin_in = 1'b0; sub_in = 1'b0;
        rst_exp = '{sum: 64'h0, cout: 1'b0, ovf: 1'b0, zero: 1'b1};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset out_valid", 64'(ov), 64'd0);
            chk_res("reset outputs", act(2), rst_exp);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("in_ready after reset", 64'(rdy[2]), 64'd1);

        foreach (tbl[i]) run_vec(tbl[i]);

        // All-ones plus carry-in must wrap to zero with carry out at every width.
        a_in = '1; b_in = '0; cin_in = 1'b1; sub_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("w%0d corner valid", widths[i]), 64'(ov[i]), 64'd1);
            chk($sformatf("w%0d corner sum", widths[i]), o_sum[i], 64'd0);
            chk($sformatf("w%0d corner cout", widths[i]), 64'(o_cout[i]), 64'd1);
        end
        tick();

        // Back-pressure: four pairs, consumer stalls on cycles 3-6.
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = {$urandom, $urandom};
            bp_b[i] = {$urandom, $urandom};
        end
        base = npop; sent = 0; c = 0; prev_stall = 1'b0; prev = '0;
        while ((sent < 4 || npop - base < 4) && c < 40) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 4);
            a_in = bp_a[(sent < 4) ? sent : 0];
            b_in = bp_b[(sent < 4) ? sent : 0];
            cin_in = 1'b0; sub_in = sent[0];
            #1;
            if (prev_stall) begin
                chk_res("bp hold", act(2), prev);
                chk("bp hold valid", 64'(ov[2]), 64'd1);
            end
            chk("bp in_ready", 64'(rdy[2]), 64'(!(q[2].size() == 2 && !out_ready)));
            acc = in_valid && rdy[2];
            prev_stall = ov[2] && !out_ready;
            prev = act(2);
            tick();
            if (acc) sent++;
            c++;
        end
        chk("bp results", 64'(npop - base), 64'd4);

        // Reset while the pipe holds data: nothing may come out afterwards.
        out_ready = 1'b0; in_valid = 1'b1;
        a_in = 64'h11; b_in = 64'h22;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre-reset valid", 64'(ov[2]), 64'd1);
        rst = 1'b1;
        tick();
        chk("mid reset valid", 64'(ov[2]), 64'd0);
        chk("mid reset zero", 64'(o_zero[2]), 64'd1);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post reset idle", 64'(ov), 64'd0);
        end

        // Full throughput: 100 back-to-back random pairs.
        base = npop;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
            cin_in = $urandom_range(0, 1); sub_in = $urandom_range(0, 1);
            if (i % 25 == 0) begin
                #1;
                chk("stream in_ready", 64'(rdy[2]), 64'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("stream count", 64'(npop - base), 64'd100);

        // Random valid/ready traffic.
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
            cin_in = $urandom_range(0, 1); sub_in = $urandom_range(0, 1);
            #1;
            if (i % 10 == 0)
                chk("rand in_ready", 64'(rdy[2]), 64'(!(q[2].size() == 2 && !out_ready)));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cnt = 0;
        while (q[2].size() != 0 && cnt < 10) begin
            tick();
            cnt++;
        end
        tick();
        for (int i = 0; i < 4; i++)
            chk($sformatf("w%0d drained", widths[i]), 64'(q[i].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

endmodule
